// File: rtl/m_fmap_relay.sv
// Feature-map relay: captures DEPTH samples from the upstream layer, then replays them to the downstream layer.
// Optional macro FMAP_RELAY_RELU_EN clamps negative samples to zero at capture.
module m_fmap_relay #(
  parameter int unsigned     AW    = 13,
  parameter logic [AW-1:0]   DEPTH = 13'd7744
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic signed [15:0] data_in,
  input  logic               save_in,
  input  logic               ds_ready,
  output logic signed [15:0] map_out,
  output logic               start_out,
  output logic               done,
  output logic               overflow
);

  localparam int unsigned   MAW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = DEPTH - AW'(1);

  typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [AW-1:0]      wr_cnt;
  logic [AW-1:0]      rd_cnt;
  logic signed [15:0] mem [0:DEPTH-1];
  logic               wr_en_c;
  logic               rd_en_c;
  logic [MAW-1:0]     wr_addr_c;
  logic [MAW-1:0]     rd_addr_c;
  logic signed [15:0] wr_data_c;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_nxt;
  end

  // Next state and memory strobes; the first read is issued on the WAIT->DRAIN edge
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (save_in && wr_cnt == LAST) state_nxt = S_WAIT;
      S_WAIT:  if (ds_ready) state_nxt = S_DRAIN;
      S_DRAIN: if (!ds_ready && rd_cnt == DEPTH) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_FILL;
    endcase
    wr_en_c   = (state == S_FILL) && save_in && (wr_cnt != DEPTH);
    rd_en_c   = (state_nxt == S_DRAIN) && (rd_cnt != DEPTH);
    wr_addr_c = MAW'(wr_cnt);
    rd_addr_c = MAW'(rd_cnt);
  end

`ifdef FMAP_RELAY_RELU_EN
  assign wr_data_c = data_in[15] ? 16'sd0 : data_in;
`else
  assign wr_data_c = data_in;
`endif

  // Sample storage; contents are treated as invalid after reset
  always_ff @(posedge clk_in) begin
    if (rst_n && wr_en_c) mem[wr_addr_c] <= wr_data_c;
  end

  // Counters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      map_out   <= '0;
      start_out <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_c) wr_cnt <= wr_cnt + AW'(1);
      if (rd_en_c) rd_cnt <= rd_cnt + AW'(1);
      map_out   <= rd_en_c ? mem[rd_addr_c] : 16'sd0;
      start_out <= (state_nxt == S_DRAIN);
      done      <= (state_nxt == S_DONE);
      if (save_in && state != S_FILL) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_m_fmap_relay.sv
// Directed bench for m_fmap_relay (DEPTH=4): stimulus pushes expected replay values, a monitor pops and compares.
module tb_m_fmap_relay;

  localparam int unsigned   AW    = 3;
  localparam logic [AW-1:0] DEPTH = 3'd4;

  logic               clk_in   = 1'b0;
  logic               rst_n    = 1'b0;
  logic signed [15:0] data_in  = '0;
  logic               save_in  = 1'b0;
  logic               ds_ready = 1'b0;
  logic signed [15:0] map_out;
  logic               start_out;
  logic               done;
  logic               overflow;

  int checks = 0;
  int errors = 0;
  int k      = 0;
  logic signed [15:0] exp_q [$];

  m_fmap_relay #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .save_in  (save_in),
    .ds_ready (ds_ready),
    .map_out  (map_out),
    .start_out(start_out),
    .done     (done),
    .overflow (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [15:0] relu(input logic signed [15:0] v);
`ifdef FMAP_RELAY_RELU_EN
    return v[15] ? 16'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // One save pulse followed by an idle gap cycle
  task automatic fill(input logic signed [15:0] v, input bit push);
    if (push) exp_q.push_back(relu(v));
    save_in = 1'b1;
    data_in = v;
    step();
    save_in = 1'b0;
    data_in = '0;
    step();
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    chk("drained", exp_q.size(), 0);
  endtask

  // Monitor: first DEPTH drain cycles carry stored samples, later ones must be zero
  always @(negedge clk_in) begin
    if (start_out) begin
      if (k < 4) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample k=%0d got %0d expected none", k, map_out);
        end else begin
          chk("replay", int'(map_out), int'(exp_q.pop_front()));
        end
      end else begin
        chk("flush", int'(map_out), 0);
      end
      k++;
    end else begin
      k = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state, then gapped fill with ds_ready already high
    do_reset();
    chk("rst_start", start_out, 0);
    chk("rst_map", int'(map_out), 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    ds_ready = 1'b1;
    fill(16'sd5, 1'b1);
    fill(-16'sd3, 1'b1);
    fill(16'sd7, 1'b1);
    exp_q.push_back(relu(16'sd9));
    save_in = 1'b1;
    data_in = 16'sd9;
    step();
    save_in = 1'b0;
    chk("wait_start", start_out, 0);
    step();
    chk("drain_start", start_out, 1);
    wait_empty(10);
    step();
    step();
    step();
    ds_ready = 1'b0;
    step();
    chk("t1_done", done, 1);
    chk("t1_start", start_out, 0);
    chk("t1_map", int'(map_out), 0);
    chk("t1_ovf", overflow, 0);

    // Downstream holds off, then an early ds_ready drop is ignored
    do_reset();
    ds_ready = 1'b0;
    fill(16'sd10, 1'b1);
    fill(16'sd20, 1'b1);
    fill(16'sd30, 1'b1);
    fill(16'sd40, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_start", start_out, 0);
      chk("hold_map", int'(map_out), 0);
      step();
    end
    ds_ready = 1'b1;
    step();
    chk("rise_start", start_out, 1);
    chk("rise_map", int'(map_out), 10);
    step();
    step();
    ds_ready = 1'b0;
    step();
    chk("early_low_start", start_out, 1);
    chk("early_low_done", done, 0);
    ds_ready = 1'b1;
    step();
    step();
    step();
    ds_ready = 1'b0;
    step();
    chk("t3_done", done, 1);
    chk("t3_start", start_out, 0);
    chk("t3_map", int'(map_out), 0);
    ds_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("done_sticky", done, 1);
    end
    chk("t3_queue", exp_q.size(), 0);

    // save_in during DRAIN flags overflow without disturbing replay
    do_reset();
    ds_ready = 1'b1;
    fill(16'sd100, 1'b1);
    fill(-16'sd200, 1'b1);
    fill(16'sd300, 1'b1);
    fill(16'sd400, 1'b1);
    save_in = 1'b1;
    data_in = 16'sd555;
    step();
    save_in = 1'b0;
    data_in = '0;
    chk("ovf_set", overflow, 1);
    wait_empty(10);
    ds_ready = 1'b0;
    step();
    step();
    chk("t4_done", done, 1);
    chk("ovf_sticky", overflow, 1);

    // Reset clears sticky flags; reset mid-fill abandons the frame
    do_reset();
    chk("r5_done", done, 0);
    chk("r5_ovf", overflow, 0);
    chk("r5_start", start_out, 0);
    ds_ready = 1'b1;
    fill(16'sd7, 1'b0);
    fill(16'sd8, 1'b0);
    rst_n   = 1'b0;
    save_in = 1'b1;
    data_in = 16'sd99;
    step();
    save_in = 1'b0;
    data_in = '0;
    rst_n   = 1'b1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_start", start_out, 0);
    fill(16'sd1, 1'b1);
    fill(16'sd2, 1'b1);
    fill(16'sd3, 1'b1);
    fill(16'sd4, 1'b1);
    wait_empty(10);
    step();
    step();
    ds_ready = 1'b0;
    step();
    chk("t5_done", done, 1);
    chk("t5_ovf", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
